// File: rtl/field_select_rise_detect.sv
// Single-bit rising-edge detector: registers the previous level and flags a low-to-high step.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic rise_o
);

    logic prev_q;

    // Previous-level register, sampled every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/field_select.sv
// Edit-field selector for the alarm clock set path: steps the selected display field on
// button edges and generates the blink phase that flashes it.
module field_select #(
    parameter  int NUM_FIELDS  = 2,
    parameter  int RESET_FIELD = 1,
    parameter  int WRAP        = 1,
    parameter  int BLINK_DIV   = 25000000,
    localparam int IDX_W       = $clog2(NUM_FIELDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  editMode,
    input  logic                  moveLeft,
    input  logic                  moveRight,
    output logic [IDX_W-1:0]      selected,
    output logic [NUM_FIELDS-1:0] selectedOneHot,
    output logic                  blinkOn,
    output logic                  fieldChanged
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX     = IDX_W'(NUM_FIELDS - 1);
    localparam logic [IDX_W-1:0]      RESET_IDX    = IDX_W'(RESET_FIELD);
    localparam logic [NUM_FIELDS-1:0] RESET_ONEHOT = NUM_FIELDS'(1) << RESET_FIELD;
    localparam logic [CNT_W-1:0]      CNT_LAST     = CNT_W'(BLINK_DIV - 1);

    logic rise_l_s;
    logic rise_r_s;
    logic rise_e_s;

    logic [IDX_W-1:0]      sel_q,     sel_d;
    logic [NUM_FIELDS-1:0] onehot_q,  onehot_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic                  blink_q,   blink_d;
    logic                  changed_q, changed_d;
    logic [IDX_W-1:0]      move_idx_s;

    rise_detect u_rise_left  (.clk(clk), .reset(reset), .level_i(moveLeft),  .rise_o(rise_l_s));
    rise_detect u_rise_right (.clk(clk), .reset(reset), .level_i(moveRight), .rise_o(rise_r_s));
    rise_detect u_rise_edit  (.clk(clk), .reset(reset), .level_i(editMode),  .rise_o(rise_e_s));

    // Candidate index from the button edges; simultaneous edges cancel out
    always_comb begin
        move_idx_s = sel_q;
        if (rise_l_s && !rise_r_s) begin
            if (sel_q == LAST_IDX) begin
                move_idx_s = (WRAP != 0) ? {IDX_W{1'b0}} : sel_q;
            end else begin
                move_idx_s = sel_q + IDX_W'(1);
            end
        end else if (rise_r_s && !rise_l_s) begin
            if (sel_q == {IDX_W{1'b0}}) begin
                move_idx_s = (WRAP != 0) ? LAST_IDX : sel_q;
            end else begin
                move_idx_s = sel_q - IDX_W'(1);
            end
        end else begin
            move_idx_s = sel_q;
        end
    end

    // Next-state: edit entry wins over moves; a real change restarts the blink phase visible
    always_comb begin
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        blink_d   = blink_q;
        changed_d = 1'b0;
        onehot_d  = {NUM_FIELDS{1'b0}};
        if (rise_e_s) begin
            sel_d   = RESET_IDX;
            cnt_d   = {CNT_W{1'b0}};
            blink_d = 1'b1;
        end else if (!editMode) begin
            cnt_d   = {CNT_W{1'b0}};
            blink_d = 1'b1;
        end else if (move_idx_s != sel_q) begin
            sel_d     = move_idx_s;
            cnt_d     = {CNT_W{1'b0}};
            blink_d   = 1'b1;
            changed_d = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            blink_d = ~blink_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        for (int i = 0; i < NUM_FIELDS; i++) begin
            onehot_d[i] = (sel_d == IDX_W'(i));
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q     <= RESET_IDX;
            onehot_q  <= RESET_ONEHOT;
            cnt_q     <= {CNT_W{1'b0}};
            blink_q   <= 1'b1;
            changed_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            onehot_q  <= onehot_d;
            cnt_q     <= cnt_d;
            blink_q   <= blink_d;
            changed_q <= changed_d;
        end
    end

    assign selected       = sel_q;
    assign selectedOneHot = onehot_q;
    assign blinkOn        = blink_q;
    assign fieldChanged   = changed_q;

endmodule

// File: tb/tb_field_select.sv
// Self-checking bench: a wrapping and a saturating field_select (3 fields, reset field 2,
// blink divider 4) driven by the same buttons and checked against hand-derived expectations.
module tb_field_select;

    logic clk = 1'b0;
    logic reset;
    logic editMode;
    logic moveLeft;
    logic moveRight;

    logic [1:0] sel_w, sel_s;
    logic [2:0] oh_w, oh_s;
    logic       bl_w, bl_s;
    logic       fc_w, fc_s;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic e;
        logic l;
        logic r;
        int   sw;
        int   ss;
        logic fw;
        logic fs;
    } vec_t;

    typedef struct {
        int   sw;
        int   ss;
        logic fw;
        logic fs;
        logic e;
    } exp_t;

    vec_t tbl[23];
    exp_t sb_q[$];

    field_select #(.NUM_FIELDS(3), .RESET_FIELD(2), .WRAP(1), .BLINK_DIV(4)) dut_w (
        .clk(clk), .reset(reset), .editMode(editMode), .moveLeft(moveLeft),
        .moveRight(moveRight), .selected(sel_w), .selectedOneHot(oh_w),
        .blinkOn(bl_w), .fieldChanged(fc_w)
    );

    field_select #(.NUM_FIELDS(3), .RESET_FIELD(2), .WRAP(0), .BLINK_DIV(4)) dut_s (
        .clk(clk), .reset(reset), .editMode(editMode), .moveLeft(moveLeft),
        .moveRight(moveRight), .selected(sel_s), .selectedOneHot(oh_s),
        .blinkOn(bl_s), .fieldChanged(fc_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one input vector, then sample #1 after the next rising edge.
    task automatic tick(input logic e, input logic l, input logic r);
        editMode  = e;
        moveLeft  = l;
        moveRight = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_both(input string name, input int sw, input int ss,
                              input logic fw, input logic fs);
        check({name, " sel_w"}, int'(sel_w), sw);
        check({name, " sel_s"}, int'(sel_s), ss);
        check({name, " fc_w"}, int'(fc_w), int'(fw));
        check({name, " fc_s"}, int'(fc_s), int'(fs));
    endtask

    initial begin
        exp_t ex;
        logic [2:0] oh_exp;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2, 2, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1, 1, 1'b1, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 2, 0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 2, 0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 0, 1, 1'b1, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 0, 1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1, 2, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1, 2, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 2, 2, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 2, 2, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 1, 1, 1'b1, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 1, 1, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1, 1, 1'b0, 1'b0};
        tbl[21] = '{1'b1, 1'b1, 1'b0, 2, 2, 1'b0, 1'b0};
        tbl[22] = '{1'b1, 1'b0, 1'b0, 2, 2, 1'b0, 1'b0};

        reset     = 1'b1;
        editMode  = 1'b0;
        moveLeft  = 1'b0;
        moveRight = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_both("reset", 2, 2, 1'b0, 1'b0);
        check("reset onehot_w", int'(oh_w), 4);
        check("reset blink_w", int'(bl_w), 1);
        reset = 1'b0;

        // Table-driven vectors through a scoreboard queue
        for (int i = 0; i < 23; i++) begin
            ex = '{tbl[i].sw, tbl[i].ss, tbl[i].fw, tbl[i].fs, tbl[i].e};
            sb_q.push_back(ex);
            tick(tbl[i].e, tbl[i].l, tbl[i].r);
            ex = sb_q.pop_front();
            check_both($sformatf("vec%0d", i), ex.sw, ex.ss, ex.fw, ex.fs);
            oh_exp = 3'b001 << ex.sw;
            check($sformatf("vec%0d onehot_w", i), int'(oh_w), int'(oh_exp));
            oh_exp = 3'b001 << ex.ss;
            check($sformatf("vec%0d onehot_s", i), int'(oh_s), int'(oh_exp));
            if (!ex.e) begin
                check($sformatf("vec%0d blink_idle", i), int'(bl_w), 1);
            end
        end

        // Holding a button for 10 cycles moves only once
        tick(1'b1, 1'b0, 1'b1);
        check_both("hold first", 1, 1, 1'b1, 1'b1);
        for (int i = 0; i < 9; i++) begin
            tick(1'b1, 1'b0, 1'b1);
            check_both($sformatf("hold%0d", i), 1, 1, 1'b0, 1'b0);
        end
        tick(1'b1, 1'b0, 1'b0);

        // Fresh start for the blink sequence
        reset = 1'b1;
        editMode = 1'b0;
        moveRight = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        check("blink edit off", int'(bl_w), 1);
        tick(1'b1, 1'b0, 1'b0);
        check("blink k0", int'(bl_w), 1);
        for (int k = 1; k < 14; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            check($sformatf("blink_w k%0d", k), int'(bl_w), ((k / 4) % 2 == 0) ? 1 : 0);
            check($sformatf("blink_s k%0d", k), int'(bl_s), ((k / 4) % 2 == 0) ? 1 : 0);
        end
        tick(1'b1, 1'b0, 1'b1);
        check_both("blink move", 1, 1, 1'b1, 1'b1);
        check("blink after move", int'(bl_w), 1);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        check_both("to zero", 0, 0, 1'b1, 1'b1);
        for (int k = 1; k < 4; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            check($sformatf("restart k%0d", k), int'(bl_w), 1);
        end
        tick(1'b1, 1'b0, 1'b0);
        check("restart low", int'(bl_w), 0);
        check("restart low sel", int'(sel_w), 0);

        // Asynchronous reset mid-blink with a button being pressed
        moveRight = 1'b1;
        #2;
        reset = 1'b1;
        moveRight = 1'b0;
        editMode = 1'b0;
        #1;
        check("async sel_w", int'(sel_w), 2);
        check("async onehot_w", int'(oh_w), 4);
        check("async blink_w", int'(bl_w), 1);
        check("async fc_w", int'(fc_w), 0);
        check("async sel_s", int'(sel_s), 2);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
